// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter.
//   DIGIT_W       width of one BCD digit
//   DIGIT_MAX     largest legal BCD digit value
//   MAX_DIGITS    widest counter the compare helper supports
//   is_bcd_digit  true when a nibble holds 0-9
//   bcd_ge        decimal a >= b over the low n digits, MSD first
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  DIGIT_MAX  = 4'd9;
    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned MAX_W      = DIGIT_W * MAX_DIGITS;

    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_MAX;
    endfunction

    // Operands are zero-extended to MAX_W by the caller. The first differing
    // digit from the top decides; all-equal means a >= b.
    function automatic logic bcd_ge(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b,
                                    input int unsigned      n);
        logic res;
        logic done;
        res  = 1'b1;
        done = 1'b0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (!done && (i < int'(n))) begin
                if (a[DIGIT_W*i +: DIGIT_W] > b[DIGIT_W*i +: DIGIT_W]) begin
                    res  = 1'b1;
                    done = 1'b1;
                end else if (a[DIGIT_W*i +: DIGIT_W] < b[DIGIT_W*i +: DIGIT_W]) begin
                    res  = 1'b0;
                    done = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter.
//   clk, reset       clock, asynchronous active-low reset
//   clr, load        synchronous clear / parallel load (clr wins)
//   load_d           digit value for load
//   inc, dec         counter-wide step request (inc wins)
//   carry_in         this digit steps up when inc && carry_in
//   borrow_in        this digit steps down when dec && borrow_in
//   q                digit value, always 0-9
//   carry_out        digit rolls 9 -> 0 on this step
//   borrow_out       digit rolls 0 -> 9 on this step
module bcd_digit
    import bcd_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_d,
    input  logic               inc,
    input  logic               dec,
    input  logic               carry_in,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out,
    output logic               borrow_out
);

    logic               step_up;
    logic               step_dn;
    logic [DIGIT_W-1:0] q_d;

    assign step_up    = inc && carry_in;
    assign step_dn    = !inc && dec && borrow_in;
    assign carry_out  = step_up && (q == DIGIT_MAX);
    assign borrow_out = step_dn && (q == '0);

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_d;
        end else if (step_up) begin
            q_d = (q == DIGIT_MAX) ? '0 : q + 4'd1;
        end else if (step_dn) begin
            q_d = (q == '0) ? DIGIT_MAX : q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with runtime limit, clear, load and
// wrap/saturate selection.
//   DIGITS    number of BCD digits
//   SATURATE  0 = wrap at the bounds, 1 = hold at the bounds
//   clk, reset          clock, asynchronous active-low reset
//   en, up              count enable and direction (1 = up)
//   clr, load           synchronous clear / load (clr > load > count)
//   load_val, limit     BCD load value and inclusive upper bound
//   q                   current count, digit 0 in q[3:0]
//   tc                  combinational terminal count
//   wrap, load_err      registered single-cycle event pulses
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int unsigned W = DIGIT_W * DIGITS;

    logic          limit_ok;
    logic          load_ok;
    logic [W-1:0]  lim_eff;
    logic          at_limit;
    logic          at_zero;
    logic          cnt_up;
    logic          cnt_dn;
    logic          wrap_up;
    logic          wrap_dn;
    logic          dig_clr;
    logic          dig_load;
    logic [W-1:0]  dig_load_d;
    logic          dig_inc;
    logic          dig_dec;
    logic [DIGITS:0] carry;
    logic [DIGITS:0] borrow;
    logic          unused_chain;

    always_comb begin
        limit_ok = 1'b1;
        load_ok  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            limit_ok &= is_bcd_digit(limit[DIGIT_W*i +: DIGIT_W]);
            load_ok  &= is_bcd_digit(load_val[DIGIT_W*i +: DIGIT_W]);
        end
    end

    // An illegal limit falls back to the full decimal range.
    assign lim_eff  = limit_ok ? limit : {DIGITS{DIGIT_MAX}};
    assign at_limit = bcd_ge(MAX_W'(q), MAX_W'(lim_eff), DIGITS);
    assign at_zero  = (q == '0);
    assign tc       = up ? at_limit : at_zero;

    assign cnt_up  = !clr && !load && en && up;
    assign cnt_dn  = !clr && !load && en && !up;
    assign wrap_up = cnt_up && at_limit && !SATURATE;
    assign wrap_dn = cnt_dn && at_zero && !SATURATE;

    // Bound events bypass the ripple: wrap up is a clear, wrap down loads L.
    assign dig_clr    = clr || wrap_up;
    assign dig_load   = (load && load_ok) || wrap_dn;
    assign dig_load_d = wrap_dn ? lim_eff : load_val;
    assign dig_inc    = cnt_up && !at_limit;
    assign dig_dec    = cnt_dn && !at_zero;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .clr        (dig_clr),
            .load       (dig_load),
            .load_d     (dig_load_d[DIGIT_W*g +: DIGIT_W]),
            .inc        (dig_inc),
            .dec        (dig_dec),
            .carry_in   (carry[g]),
            .borrow_in  (borrow[g]),
            .q          (q[DIGIT_W*g +: DIGIT_W]),
            .carry_out  (carry[g+1]),
            .borrow_out (borrow[g+1])
        );
    end

    // The top digit never carries or borrows out: bounds are handled above.
    assign unused_chain = carry[DIGITS] ^ borrow[DIGITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_up || wrap_dn;
            load_err <= !clr && load && !load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter, DIGITS=4. A wrapping
// and a saturating instance share the same stimulus.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, up, clr, load;
    logic [15:0] load_val, limit;

    logic [15:0] q, qs;
    logic        tc, wrap, load_err;
    logic        tcs, wraps, load_errs;

    int tests  = 0;
    int failed = 0;

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit),
        .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    bcd_updown_counter #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .limit(limit),
        .q(qs), .tc(tcs), .wrap(wraps), .load_err(load_errs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = '0; limit = 16'h9999;
        #2;
        chk("por_q", q, 16'h0000);
        chk("por_wrap", {15'd0, wrap}, 16'd0);
        chk("por_lerr", {15'd0, load_err}, 16'd0);

        @(negedge clk); reset = 1'b1;
        do_load(16'h0347);
        chk("load_0347", q, 16'h0347);

        // Asynchronous reset mid-count, checked before any edge.
        en = 1'b1; up = 1'b1;
        #2; reset = 1'b0; #1;
        chk("async_rst_q", q, 16'h0000);
        chk("async_rst_wrap", {15'd0, wrap}, 16'd0);
        @(negedge clk); reset = 1'b1;
        step();
        chk("after_rst_up", q, 16'h0001);
        en = 1'b0;

        // Ripple carry.
        do_load(16'h0999);
        en = 1'b1; step(); en = 1'b0;
        chk("ripple_1000", q, 16'h1000);
        chk("ripple_nowrap", {15'd0, wrap}, 16'd0);

        do_load(16'h9998);
        en = 1'b1; step();
        chk("cnt_9999", q, 16'h9999);
        chk("tc_9999", {15'd0, tc}, 16'd1);
        step();
        chk("wrap_0000", q, 16'h0000);
        chk("wrap_pulse", {15'd0, wrap}, 16'd1);
        step();
        chk("wrap_0001", q, 16'h0001);
        chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);
        en = 1'b0;

        // Down wrap to programmable limit; saturating twin holds at 0.
        limit = 16'h0059;
        do_load(16'h0001);
        en = 1'b1; up = 1'b0; step();
        chk("dn_0000", q, 16'h0000);
        chk("dn_tc", {15'd0, tc}, 16'd1);
        step();
        chk("dn_wrap_0059", q, 16'h0059);
        chk("dn_wrap_pulse", {15'd0, wrap}, 16'd1);
        chk("sat_dn_hold", qs, 16'h0000);
        chk("sat_dn_nowrap", {15'd0, wraps}, 16'd0);
        en = 1'b0;

        // Saturate at limit going up.
        do_load(16'h0059);
        up = 1'b1; en = 1'b1;
        step(); step(); step();
        chk("sat_up_hold", qs, 16'h0059);
        chk("sat_up_nowrap", {15'd0, wraps}, 16'd0);
        chk("sat_up_tc", {15'd0, tcs}, 16'd1);
        chk("wrapdut_0002", q, 16'h0002);
        en = 1'b0;

        // Load validation.
        do_load(16'h0A12);
        chk("bad_load_q", q, 16'h0002);
        chk("bad_load_err", {15'd0, load_err}, 16'd1);
        step();
        chk("bad_load_err_clr", {15'd0, load_err}, 16'd0);
        do_load(16'h0120);
        chk("load_over_lim", q, 16'h0120);
        en = 1'b1; step(); en = 1'b0;
        chk("over_lim_wrap_q", q, 16'h0000);
        chk("over_lim_wrap", {15'd0, wrap}, 16'd1);

        // Priority.
        do_load(16'h0347);
        clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 16'h0500;
        step();
        chk("prio_clr", q, 16'h0000);
        clr = 1'b0;
        step();
        chk("prio_load", q, 16'h0500);
        load = 1'b0; en = 1'b0;

        // Illegal limit falls back to 9999.
        limit = 16'h00F0;
        do_load(16'h9999);
        chk("badlim_tc", {15'd0, tc}, 16'd1);
        en = 1'b1; step(); en = 1'b0;
        chk("badlim_wrap_q", q, 16'h0000);
        chk("badlim_wrap", {15'd0, wrap}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with a programmable runtime limit, synchronous clear and load, and selectable wrap or saturate behaviour. It generalises the fixed 4-digit 0–9999 counter into a reusable block for display, timer and event-count paths. It drives decimal display logic directly and flags terminal count and wrap events to downstream control.

## Interface
- DIGITS, 4: number of BCD digits; counter width is 4*DIGITS bits, value range 0 to 10^DIGITS−1.
- SATURATE, 0: 0 = wrap at the bounds; 1 = hold at the bounds.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- en  input  1  count enable; has no effect on clr or load.
- up  input  1  direction: 1 = count up, 0 = count down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  4*DIGITS  BCD value to load.
- limit  input  4*DIGITS  BCD upper bound, inclusive.
- q  output  4*DIGITS  current BCD count; digit 0 is the least significant, in q[3:0].
- tc  output  1  terminal count; combinational.
- wrap  output  1  one-cycle pulse on a wrap event; registered.
- load_err  output  1  one-cycle pulse on a rejected load; registered.

## Operation
- Priority per cycle: clr > load > (en count) > hold.
- clr: q ← 0. wrap and load_err stay 0.
- load, with every load_val digit ≤ 9: q ← load_val. This applies even when load_val exceeds limit.
- load, with any load_val digit > 9: q unchanged and load_err = 1 for one cycle.
- Effective limit L: equals limit when every digit ≤ 9; otherwise all digits are 9.
- Up count, en=1, up=1:
  - q < L: BCD increment with a ripple carry across digits.
  - q ≥ L and SATURATE=0: q ← 0 and wrap = 1.
  - q ≥ L and SATURATE=1: q holds and wrap = 0.
- Down count, en=1, up=0:
  - q > 0: BCD decrement with a ripple borrow. This is normal even when q > L.
  - q = 0 and SATURATE=0: q ← L and wrap = 1.
  - q = 0 and SATURATE=1: q holds and wrap = 0.
- tc definition: tc = (up && q ≥ L) || (!up && q == 0). tc is independent of en.
- Digit values: every digit of q is always in 0–9; the counter never produces an invalid BCD digit.
- Comparisons against L: decimal magnitude comparisons, evaluated digit by digit from the most significant digit.

## Timing
- Reset, asynchronous, reset=0: q = 0, wrap = 0, load_err = 0 immediately; tc follows from q and up.
- Latency: q, wrap and load_err update on the same rising edge that samples the controls. There is one cycle of latency from control to output.
- wrap: asserted only in the cycle after the wrapping edge, and for that single cycle only; it is coincident with the new q.
- Reset release: the first active edge after reset rises obeys the normal priority rules.
- limit changing mid-count: takes effect on the next edge; there is no pipeline on limit.
- tc: purely combinational from q, up and limit; it may glitch when up or limit change.

## Structure
- Package bcd_pkg:
  - constants DIGIT_W = 4 and DIGIT_MAX = 4'd9;
  - function is_bcd_digit;
  - function bcd_ge(a, b, n) for the digit-wise magnitude compare.
- Sub-module bcd_digit, one per digit via generate. It provides:
  - a 4-bit register with inputs inc, dec, load_d, clr and carry_in/borrow_in;
  - outputs carry_out (digit = 9 and inc) and borrow_out (digit = 0 and dec).
- Top level provides:
  - limit sanitising;
  - the compare and tc logic;
  - wrap and saturate decisions, which override the ripple with a parallel load of 0 or L;
  - the wrap and load_err registers.

## Test plan
All scenarios use DIGITS=4.
- Reset: assert reset mid-count with q=0347 → q=0000 and wrap=0 with no clock; after release, en=1 and up=1 give q=0001 after one edge.
- Ripple carry: load 0999, up, en → q=1000 and no wrap. Then with limit=9999 count from 9998 → 9999 (tc=1), then 0000 with wrap=1 for exactly one cycle.
- Programmable limit, down wrap: limit=0059, down from 0001 → 0000 (tc=1), then 0059 with wrap=1.
- SATURATE=1: limit=0059, q=0059, up for 3 cycles → q stays 0059, wrap=0, tc=1. Down from 0000 → stays 0000.
- Load validation:
  - load_val=0A12 → q unchanged and load_err=1 for one cycle;
  - load_val=0120 with limit=0059 → q=0120, and the next up edge gives 0000 with wrap=1.
- Priority: clr=1, load=1, en=1 in the same cycle → q=0000. load=1 and en=1 with load_val=0500 → q=0500, not 0501. Invalid limit 00F0 with up from 9999 → 0000 with wrap=1.
